// File: rtl/sparse_array_sequencer.sv
// sparse_array_sequencer
//   Job controller for the N x N sparse systolic PE array. An accepted start
//   streams k_len operand-buffer rows into the skew feeders. It then flushes
//   the skew and PE pipeline for 2N cycles and pulses done for one cycle.
//   While busy, it accumulates MAC activity from the per-PE valid_op flags.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         job request, sampled only in IDLE
//   k_len         reduction length, latched with an accepted start
//   valid_op_vec  concatenated valid_op flags of all N*N PEs
//   busy          job in progress (STREAM or FLUSH)
//   done          one-cycle pulse at end of job
//   rd_en         operand-buffer read enable
//   rd_addr       operand-buffer row address
//   feed_en       operand valid into skew feeders (rd_en delayed one cycle)
//   flush         high in FLUSH; skew feeders inject zeros
//   mac_count     saturating MAC count of the current or last job
//   cycle_count   saturating busy-cycle count of the current or last job

module sparse_array_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned KW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [KW-1:0]  k_len,
    input  logic [N*N-1:0] valid_op_vec,
    output logic           busy,
    output logic           done,
    output logic           rd_en,
    output logic [KW-1:0]  rd_addr,
    output logic           feed_en,
    output logic           flush,
    output logic [31:0]    mac_count,
    output logic [31:0]    cycle_count
);

    localparam int unsigned PW = $clog2(N*N + 1);
    localparam int unsigned FW = $clog2(2*N);
    // Buffer latency (1) + skew stages (2N-2) + PE register (1) = 2N cycles.
    localparam logic [FW-1:0] FLUSH_INIT = FW'(2*N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] k_reg;
    logic [FW-1:0] flush_cnt;

    logic [PW-1:0] pop;
    logic [32:0]   mac_sum;
    logic [31:0]   mac_next;
    logic [31:0]   cycle_next;
    logic          last_row;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N*N; i++) begin
            pop = pop + PW'(valid_op_vec[i]);
        end
    end

    // The carry-out bit of the 33-bit sum marks an overflow, which saturates.
    always_comb begin
        mac_sum    = {1'b0, mac_count} + 33'(pop);
        mac_next   = mac_sum[32] ? '1 : mac_sum[31:0];
        cycle_next = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
        last_row   = (rd_addr == k_reg - KW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k_reg       <= '0;
            flush_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            feed_en     <= 1'b0;
            flush       <= 1'b0;
            mac_count   <= '0;
            cycle_count <= '0;
        end else begin
            feed_en <= rd_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_reg       <= k_len;
                        mac_count   <= '0;
                        cycle_count <= '0;
                        rd_addr     <= '0;
                        if (k_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_STREAM;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                        end
                    end
                end

                S_STREAM: begin
                    mac_count   <= mac_next;
                    cycle_count <= cycle_next;
                    // rd_addr holds at k_reg-1 on the last row and never wraps.
                    if (last_row) begin
                        state     <= S_FLUSH;
                        rd_en     <= 1'b0;
                        flush     <= 1'b1;
                        flush_cnt <= FLUSH_INIT;
                    end else begin
                        rd_addr <= rd_addr + KW'(1);
                    end
                end

                S_FLUSH: begin
                    mac_count   <= mac_next;
                    cycle_count <= cycle_next;
                    if (flush_cnt == '0) begin
                        state <= S_DONE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_array_sequencer.sv
// Directed self-checking bench for sparse_array_sequencer (N=4, KW=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Cycle 0 is the cycle in which start is presented; the first busy cycle is
// cycle 1.

module tb_sparse_array_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic [15:0] valid_op_vec;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        feed_en;
    logic        flush;
    logic [31:0] mac_count;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    sparse_array_sequencer #(
        .N  (4),
        .KW (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .valid_op_vec (valid_op_vec),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .feed_en      (feed_en),
        .flush        (flush),
        .mac_count    (mac_count),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from IDLE and compares its trace against hand-computed
    // figures. With inject set, start is held high (k_len=9) for the whole
    // job including the DONE cycle; it must have no effect.
    task automatic run_job(input string nm, input logic [7:0] k, input logic [15:0] vop,
                           input logic inject, input int exp_busy, input int exp_done,
                           input int exp_flush, input logic [31:0] exp_cyc,
                           input logic [31:0] exp_mac);
        int   busy_cnt;
        int   rd_cnt;
        int   feed_cnt;
        int   flush_cnt;
        int   done_cyc;
        int   first_rd;
        logic addr_ok;
        logic feed_ok;
        logic prev_rd;

        busy_cnt  = 0;
        rd_cnt    = 0;
        feed_cnt  = 0;
        flush_cnt = 0;
        done_cyc  = 0;
        first_rd  = 0;
        addr_ok   = 1'b1;
        feed_ok   = 1'b1;
        prev_rd   = rd_en;

        start        = 1'b1;
        k_len        = k;
        valid_op_vec = vop;
        step();

        for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
            start = inject;
            k_len = inject ? 8'd9 : k;
            if (feed_en !== prev_rd) feed_ok = 1'b0;
            if (rd_en) begin
                if (first_rd == 0) first_rd = c;
                if (rd_addr !== rd_cnt[7:0]) addr_ok = 1'b0;
                rd_cnt++;
            end
            if (busy)    busy_cnt++;
            if (feed_en) feed_cnt++;
            if (flush)   flush_cnt++;
            if (done) begin
                done_cyc = c;
            end else begin
                prev_rd = rd_en;
                step();
            end
        end

        check({nm, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({nm, "_rd_cycles"}, 32'(rd_cnt), 32'(k));
        check({nm, "_first_rd"}, 32'(first_rd), (k == 8'd0) ? 32'd0 : 32'd1);
        check({nm, "_rd_addr_seq"}, 32'(addr_ok), 32'd1);
        check({nm, "_feed_cycles"}, 32'(feed_cnt), 32'(k));
        check({nm, "_feed_delay"}, 32'(feed_ok), 32'd1);
        check({nm, "_flush_cycles"}, 32'(flush_cnt), 32'(exp_flush));
        check({nm, "_cycle_count"}, cycle_count, exp_cyc);
        check({nm, "_mac_count"}, mac_count, exp_mac);

        // DONE -> IDLE; a start held through DONE must not launch a job.
        step();
        start = 1'b0;
        k_len = 8'd0;
        check({nm, "_idle_busy"}, 32'(busy), 32'd0);
        check({nm, "_idle_done"}, 32'(done), 32'd0);
        step();
        check({nm, "_no_rerun"}, 32'({busy, rd_en}), 32'd0);
        check({nm, "_hold_cyc"}, cycle_count, exp_cyc);
        check({nm, "_hold_mac"}, mac_count, exp_mac);
    endtask

    initial begin
        int done_seen;

        rst          = 1'b1;
        start        = 1'b0;
        k_len        = 8'd0;
        valid_op_vec = 16'h0000;
        step();
        step();
        rst = 1'b0;
        step();

        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rd_en", 32'(rd_en), 32'd0);
        check("reset_feed_en", 32'(feed_en), 32'd0);
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_mac", mac_count, 32'd0);
        check("reset_cyc", cycle_count, 32'd0);

        // k=3, N=4: busy 3+8=11, done at cycle 12, flush 8 cycles.
        run_job("nominal", 8'd3, 16'h0000, 1'b0, 11, 12, 8, 32'd11, 32'd0);
        run_job("dense",   8'd3, 16'hFFFF, 1'b0, 11, 12, 8, 32'd11, 32'd176);
        run_job("sparse",  8'd3, 16'h000F, 1'b0, 11, 12, 8, 32'd11, 32'd44);

        // Activity outside a job must not reach the counters.
        valid_op_vec = 16'hFFFF;
        step();
        valid_op_vec = 16'h5A5A;
        step();
        valid_op_vec = 16'h0F0F;
        step();
        check("idle_toggle_mac", mac_count, 32'd44);
        check("idle_toggle_cyc", cycle_count, 32'd11);
        check("idle_toggle_busy", 32'(busy), 32'd0);

        // k=0: done in cycle 1, nothing streamed, counters cleared.
        run_job("zero_len", 8'd0, 16'hFFFF, 1'b0, 0, 1, 0, 32'd0, 32'd0);

        // start held through STREAM, FLUSH and DONE; original length wins.
        run_job("ignored_start", 8'd3, 16'h0000, 1'b1, 11, 12, 8, 32'd11, 32'd0);
        run_job("after_ignored", 8'd2, 16'h0000, 1'b0, 10, 11, 8, 32'd10, 32'd0);

        // Maximum legal length: 255 rows, busy 263 cycles.
        run_job("max_len", 8'd255, 16'hFFFF, 1'b0, 263, 264, 8, 32'd263, 32'd4208);

        // Reset during FLUSH: k=5 streams cycles 1..5, FLUSH starts in cycle 6.
        start        = 1'b1;
        k_len        = 8'd5;
        valid_op_vec = 16'hFFFF;
        step();
        start = 1'b0;
        repeat (6) step();
        check("pre_reset_flush", 32'(flush), 32'd1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rd_en", 32'(rd_en), 32'd0);
        check("midrst_feed_en", 32'(feed_en), 32'd0);
        check("midrst_flush", 32'(flush), 32'd0);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
        check("midrst_mac", mac_count, 32'd0);
        check("midrst_cyc", cycle_count, 32'd0);
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);

        // k=1 after reset: busy 9, done in cycle 10, two active PEs -> 18.
        run_job("post_reset", 8'd1, 16'h8001, 1'b0, 9, 10, 8, 32'd9, 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sparse_array_sequencer.md
# sparse_array_sequencer

Job controller for the N×N sparse systolic PE array. On `start` it streams `k_len` operand-buffer rows into the array's skew feeders, then flushes the skew and PE pipeline. It pulses `done` when every result has settled and accumulates MAC activity from the per-PE `valid_op` flags. It sits between the host command interface and the array, and owns the operand-buffer read port.

## Interface
Parameters:
- `N`, default 4: array dimension; the array has N*N PEs.
- `KW`, default 8: width of `k_len` and `rd_addr`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  job request; sampled only in IDLE
- `k_len`  in  KW  reduction length (rows to stream); sampled with an accepted `start`
- `valid_op_vec`  in  N*N  concatenated `valid_op` outputs of all PEs
- `busy`  out  1  job in progress (STREAM or FLUSH)
- `done`  out  1  one-cycle pulse at end of job
- `rd_en`  out  1  operand-buffer read enable
- `rd_addr`  out  KW  operand-buffer row address
- `feed_en`  out  1  operand valid into skew feeders; equals `rd_en` delayed 1 cycle
- `flush`  out  1  high in FLUSH; skew feeders inject zeros
- `mac_count`  out  32  count of executed MACs for the current or last job
- `cycle_count`  out  32  busy cycles of the current or last job

## Operation
- FSM states: IDLE, STREAM, FLUSH, DONE.
- **IDLE.** If `start`=1:
  - latch `k_len` into `k_reg`.
  - clear `mac_count`, `cycle_count` and `rd_addr`.
  - if `k_len`=0, go to DONE; otherwise go to STREAM.
  - `start`=0: stay in IDLE.
- **STREAM.**
  - `rd_en`=1 and `rd_addr` increments by 1 each cycle, producing addresses 0 … `k_reg`−1.
  - After the cycle with `rd_addr`=`k_reg`−1, go to FLUSH.
  - Load `flush_cnt`=2N−1.
- **FLUSH.**
  - `rd_en`=0 and `flush`=1.
  - `flush_cnt` decrements each cycle; leave at 0 and go to DONE.
  - FLUSH therefore lasts exactly 2N cycles: 1 cycle of buffer latency plus 2N−2 skew stages plus 1 PE register.
- **DONE.** `done`=1 for this single cycle, then go to IDLE. `start` is ignored in DONE.
- `start` in STREAM, FLUSH or DONE is ignored; it is neither queued nor does it change `k_reg`.
- **Counters.** While `busy`=1, each cycle:
  - `mac_count` += popcount(`valid_op_vec`).
  - `cycle_count` += 1.
  - Both saturate at 2^32−1.
  - Both hold their value from the end of the job until the next accepted `start`.
- `valid_op_vec` is ignored outside STREAM/FLUSH.
- **Width rules.**
  - popcount is computed at width clog2(N*N+1), then zero-extended to 32 bits.
  - `rd_addr` never wraps, because its maximum value is `k_reg`−1 ≤ 2^KW−2.
  - `k_len`=2^KW−1 is legal.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_en`, `feed_en` and `flush` = 0; `rd_addr`, `mac_count` and `cycle_count` = 0.
- `rst` asserted mid-job aborts immediately to the reset values. No `done` pulse is produced.
- Start-to-read latency: `start` sampled at edge t → `rd_en`=1 with `rd_addr`=0 from edge t+1.
- `feed_en` rises at t+2 and stays high for `k_reg` cycles.
- `busy` is high for exactly `k_reg`+2N cycles.
- `done` occurs in the cycle immediately after `busy` falls. Total latency from `start` to `done` is `k_reg`+2N+1 cycles.
- `k_len`=0: `busy` never rises, `rd_en` never rises, and `done` pulses at t+1. Both counters read 0.
- Earliest next `start` is accepted in the cycle after `done`, i.e. the IDLE cycle. There is no back-to-back overlap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Nominal job.** N=4, `k_len`=3, `start` for 1 cycle, `valid_op_vec`=0:
  - `rd_addr` sequence 0, 1, 2.
  - `feed_en` high for 3 cycles, one cycle after `rd_en`.
  - `busy` high for 11 cycles.
  - `done` 12 cycles after `start`.
  - `cycle_count`=11, `mac_count`=0.
- **Dense activity.** Same job with `valid_op_vec`=all-ones → `mac_count`=16×11=176.
- **Sparse activity.** Same job with `valid_op_vec`=16'h000F whenever `busy`=1 → `mac_count`=44. Toggle `valid_op_vec` in IDLE and confirm `mac_count` is unchanged.
- **Zero length.** `k_len`=0 → `done` the cycle after `start`; no `rd_en` and no `busy`; counters 0.
- **Ignored start.** Pulse `start` with `k_len`=9 during STREAM, FLUSH and DONE → job finishes with the original length and no second job runs. A following `start` in IDLE with `k_len`=2 runs normally, with `cycle_count`=10.
- **Reset mid-job.** Assert `rst` during FLUSH → all outputs 0 on the same cycle, with no `done`. A subsequent job with `k_len`=1 completes with `cycle_count`=9.
